// File: rtl/tile_mem.sv
// Tile scratchpad for the systolic mesh: MESHUNITS-wide A/D/B tile reads, C write-backs and a host port.
// Packing: row i occupies bits [i*TILEUNITS*BITWIDTH +: TILEUNITS*BITWIDTH]; word k of a tile sits at k*BITWIDTH.
module tile_mem #(
  parameter int unsigned ADDRSIZE  = 256,
  parameter int unsigned ADDRWIDTH = 8,
  parameter int unsigned BITWIDTH  = 8,
  parameter int unsigned MESHUNITS = 4,
  parameter int unsigned TILEUNITS = 4
) (
  input  logic                                           clock,
  input  logic                                           reset,
  output logic                                           init_done,
  input  logic [ADDRWIDTH*MESHUNITS-1:0]                 A_tile_read_addrs,
  input  logic [ADDRWIDTH*MESHUNITS-1:0]                 D_tile_read_addrs,
  input  logic [ADDRWIDTH*MESHUNITS-1:0]                 B_tile_read_addrs,
  input  logic [MESHUNITS-1:0]                           A_read_valid,
  input  logic [MESHUNITS-1:0]                           D_read_valid,
  input  logic [MESHUNITS-1:0]                           B_read_valid,
  output logic signed [BITWIDTH*MESHUNITS*TILEUNITS-1:0] A,
  output logic signed [BITWIDTH*MESHUNITS*TILEUNITS-1:0] D,
  output logic signed [BITWIDTH*MESHUNITS*TILEUNITS-1:0] B,
  output logic [MESHUNITS-1:0]                           A_out_valid,
  output logic [MESHUNITS-1:0]                           D_out_valid,
  output logic [MESHUNITS-1:0]                           B_out_valid,
  input  logic [ADDRWIDTH*MESHUNITS-1:0]                 C_tile_write_addrs,
  input  logic [MESHUNITS-1:0]                           C_write_valid,
  input  logic signed [BITWIDTH*MESHUNITS*TILEUNITS-1:0] C,
  input  logic                                           host_req_valid,
  output logic                                           host_req_ready,
  input  logic                                           host_we,
  input  logic [ADDRWIDTH-1:0]                           host_addr,
  input  logic signed [BITWIDTH*TILEUNITS-1:0]           host_wdata,
  output logic signed [BITWIDTH*TILEUNITS-1:0]           host_rdata,
  output logic                                           host_rsp_valid
);

  localparam int unsigned MW = $clog2(ADDRSIZE);
  localparam int unsigned TW = TILEUNITS * BITWIDTH;
  localparam logic [MW-1:0] LAST_PTR  = MW'(ADDRSIZE - TILEUNITS);
  localparam logic [MW-1:0] TILE_MASK = ~MW'(TILEUNITS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                            state_q, state_d;
  logic [MW-1:0]                     clear_ptr;
  logic [ADDRSIZE-1:0][BITWIDTH-1:0] mem, mem_d;
  logic                              run_c, host_acc_c;

  // Out-of-range addresses wrap, then align down to the tile boundary.
  function automatic logic [MW-1:0] tile_base(input logic [ADDRWIDTH-1:0] addr);
    return MW'(addr) & TILE_MASK;
  endfunction

  function automatic logic [TW-1:0] read_tile(input logic [MW-1:0] base);
    logic [TW-1:0] t;
    t = '0;
    for (int k = 0; k < TILEUNITS; k++) t[k*BITWIDTH +: BITWIDTH] = mem[base + MW'(k)];
    return t;
  endfunction

  always_comb begin
    state_d    = state_q;
    run_c      = (state_q == RUN);
    host_acc_c = run_c && host_req_valid && host_req_ready;
    if (state_q == CLEAR && clear_ptr == LAST_PTR) state_d = RUN;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= CLEAR;
      clear_ptr      <= '0;
      init_done      <= 1'b0;
      host_req_ready <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_done      <= (state_d == RUN);
      host_req_ready <= (state_d == RUN);
      if (state_q == CLEAR) clear_ptr <= clear_ptr + MW'(TILEUNITS);
    end
  end

  // Next memory image: later assignments win, so C rows in ascending order override the host.
  always_comb begin
    mem_d = mem;
    if (!reset) begin
      if (!run_c) begin
        for (int k = 0; k < TILEUNITS; k++) mem_d[clear_ptr + MW'(k)] = '0;
      end else begin
        if (host_acc_c && host_we) begin
          for (int k = 0; k < TILEUNITS; k++)
            mem_d[tile_base(host_addr) + MW'(k)] = host_wdata[k*BITWIDTH +: BITWIDTH];
        end
        for (int i = 0; i < MESHUNITS; i++) begin
          if (C_write_valid[i]) begin
            for (int k = 0; k < TILEUNITS; k++)
              mem_d[tile_base(C_tile_write_addrs[i*ADDRWIDTH +: ADDRWIDTH]) + MW'(k)] =
                C[i*TW + k*BITWIDTH +: BITWIDTH];
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    mem <= mem_d;
  end

  // Reads sample the pre-edge array, giving read-before-write on a same-edge collision.
  always_ff @(posedge clock) begin
    if (reset) begin
      A              <= '0;
      D              <= '0;
      B              <= '0;
      A_out_valid    <= '0;
      D_out_valid    <= '0;
      B_out_valid    <= '0;
      host_rdata     <= '0;
      host_rsp_valid <= 1'b0;
    end else begin
      for (int i = 0; i < MESHUNITS; i++) begin
        A_out_valid[i] <= run_c && A_read_valid[i];
        D_out_valid[i] <= run_c && D_read_valid[i];
        B_out_valid[i] <= run_c && B_read_valid[i];
        if (run_c && A_read_valid[i])
          A[i*TW +: TW] <= read_tile(tile_base(A_tile_read_addrs[i*ADDRWIDTH +: ADDRWIDTH]));
        if (run_c && D_read_valid[i])
          D[i*TW +: TW] <= read_tile(tile_base(D_tile_read_addrs[i*ADDRWIDTH +: ADDRWIDTH]));
        if (run_c && B_read_valid[i])
          B[i*TW +: TW] <= read_tile(tile_base(B_tile_read_addrs[i*ADDRWIDTH +: ADDRWIDTH]));
      end
      host_rsp_valid <= host_acc_c && !host_we;
      if (host_acc_c && !host_we) host_rdata <= read_tile(tile_base(host_addr));
    end
  end

endmodule
